data_mem_arbiter: RTL and testbench

- Two-port round-robin arbiter and access sequencer in front of the 8x16 data memory.
- Shares the single memory port between the CPU load/store path (port 0, "cpu_") and the debug/loader port (port 1, "dbg_").
- Uses a req/ack handshake per port and latches each request.
- Drives the memory's address, write-data, write-enable and read strobes for exactly one cycle per transaction, and registers the read data back to the requester.

---
 rtl/data_mem_arbiter_if.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 103 ++++++++++
 tb/tb_data_mem_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Request/response and memory-side signals shared between the two requesters,
// the data-memory arbiter and the 8x16 data memory.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;

    logic                  dbg_req;
    logic                  dbg_we;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata;
    logic                  dbg_ack;
    logic [DATA_WIDTH-1:0] dbg_rdata;

    logic [ADDR_WIDTH-1:0] mem_access_addr;
    logic [DATA_WIDTH-1:0] mem_write_data;
    logic                  mem_write_en;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_read_data;

    logic                  busy;

    // Requesters plus memory: drive requests and read data, observe the rest.
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
        output mem_read_data,
        input  busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read,
        input  mem_read_data,
        output busy
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port 0)
// and the debug/loader port (port 1); one IDLE -> SERVE -> RESP pass per access.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e                state_q;
    logic                  ptr_q;      // port favoured when both request
    logic                  owner_q;    // 0 = cpu, 1 = dbg
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic                  cpu_ack_q;
    logic                  dbg_ack_q;

    logic                  grant_d;
    logic                  owner_d;

    // NOTE: every always_comb output is given a default first so no latch is inferred.
    always_comb begin
        grant_d = bus.cpu_req | bus.dbg_req;
        owner_d = ptr_q;
        if (bus.cpu_req && !bus.dbg_req) begin
            owner_d = 1'b0;
        end else if (!bus.cpu_req && bus.dbg_req) begin
            owner_d = 1'b1;
        end
    end

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q <= owner_d;
                        we_q    <= owner_d ? bus.dbg_we    : bus.cpu_we;
                        addr_q  <= owner_d ? bus.dbg_addr  : bus.cpu_addr;
                        wdata_q <= owner_d ? bus.dbg_wdata : bus.cpu_wdata;
                        state_q <= SERVE;
                    end
                end
                SERVE: begin
                    // Read data is only valid while mem_read is high, i.e. now.
                    if (!we_q) begin
                        if (owner_q) begin
                            dbg_rdata_q <= bus.mem_read_data;
                        end else begin
                            cpu_rdata_q <= bus.mem_read_data;
                        end
                    end
                    cpu_ack_q <= ~owner_q;
                    dbg_ack_q <= owner_q;
                    state_q   <= RESP;
                end
                RESP: begin
                    ptr_q   <= ~owner_q;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes are gated by rst combinationally so a reset in SERVE blocks the write.
    assign bus.mem_write_en    = (state_q == SERVE) &  we_q & ~rst;
    assign bus.mem_read        = (state_q == SERVE) & ~we_q & ~rst;
    assign bus.mem_access_addr = addr_q;
    assign bus.mem_write_data  = wdata_q;

    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: an 8x16 memory, a cycle-indexed reference model,
// directed scenarios with literal expectations and a randomized two-port phase.
module tb_data_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    typedef struct {
        logic [DW-1:0] rdata;
        int            lat;
        int            n_wr;
        int            n_rd;
        int            n_busy;
        int            n_other;
    } txn_res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

    data_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Data memory: 8 words, low three address bits decoded, combinational read.
    logic [DW-1:0] mem [8] = '{default: '0};
    assign bus.mem_read_data = bus.mem_read ? mem[bus.mem_access_addr[2:0]] : '0;
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_access_addr[2:0]] = bus.mem_write_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles are numbered; g is the cycle in which the memory
    // access of the current transaction happens, the ack follows in g+1, and a new
    // grant can be sampled at the end of any cycle >= g+2.
    int            cyc = 0;
    int            g = -10;
    bit            model_valid = 1'b0;
    bit            m_owner = 1'b0;
    bit            m_we = 1'b0;
    bit            m_last = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_cpu_rd = '0;
    logic [DW-1:0] m_dbg_rd = '0;
    logic [DW-1:0] m_mem [8] = '{default: '0};

    always @(posedge clk) begin
        if (rst) begin
            g = -10; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_cpu_rd = '0; m_dbg_rd = '0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (cyc == g) begin
                if (m_we)         m_mem[m_addr[2:0]] = m_wdata;
                else if (m_owner) m_dbg_rd = m_mem[m_addr[2:0]];
                else              m_cpu_rd = m_mem[m_addr[2:0]];
            end else if (cyc == g + 1) begin
                m_last = m_owner;
            end else if (bus.cpu_req || bus.dbg_req) begin
                m_owner = (bus.cpu_req && bus.dbg_req) ? !m_last : bus.dbg_req;
                m_we    = m_owner ? bus.dbg_we    : bus.cpu_we;
                m_addr  = m_owner ? bus.dbg_addr  : bus.cpu_addr;
                m_wdata = m_owner ? bus.dbg_wdata : bus.cpu_wdata;
                g = cyc + 1;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        bit acc;
        bit ackc;
        if (model_valid) begin
            acc  = (cyc == g);
            ackc = (cyc == g + 1);
            check("busy",            32'(bus.busy),            32'(acc || ackc));
            check("mem_write_en",    32'(bus.mem_write_en),    32'(acc && m_we && !rst));
            check("mem_read",        32'(bus.mem_read),        32'(acc && !m_we && !rst));
            check("mem_access_addr", 32'(bus.mem_access_addr), 32'(m_addr));
            check("mem_write_data",  32'(bus.mem_write_data),  32'(m_wdata));
            check("cpu_ack",         32'(bus.cpu_ack),         32'(ackc && !m_owner));
            check("dbg_ack",         32'(bus.dbg_ack),         32'(ackc && m_owner));
            check("cpu_rdata",       32'(bus.cpu_rdata),       32'(m_cpu_rd));
            check("dbg_rdata",       32'(bus.dbg_rdata),       32'(m_dbg_rd));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input bit p, input bit req, input bit we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (p) begin
            bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wdata;
        end else begin
            bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
    endtask

    function automatic bit ack_of(input bit p);
        return p ? bus.dbg_ack : bus.cpu_ack;
    endfunction

    // One transaction on port p; started at #1 after an edge, returns at #1 into
    // the ack cycle with req already dropped.
    task automatic run_txn(input bit p, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, output txn_res_t r);
        bit done;
        done = 1'b0;
        r.rdata = '0; r.lat = 0; r.n_wr = 0; r.n_rd = 0; r.n_busy = 0; r.n_other = 0;
        set_port(p, 1'b1, we, addr, wdata);
        for (int i = 1; i <= 20 && !done; i++) begin
            tick();
            r.n_wr    += int'(bus.mem_write_en);
            r.n_rd    += int'(bus.mem_read);
            r.n_busy  += int'(bus.busy);
            r.n_other += int'(ack_of(!p));
            if (ack_of(p)) begin
                r.lat   = i;
                r.rdata = p ? bus.dbg_rdata : bus.cpu_rdata;
                set_port(p, 1'b0, we, addr, wdata);
                done = 1'b1;
            end
        end
        check("txn ack within budget", 32'(done), 32'(1));
        if (!done) set_port(p, 1'b0, we, addr, wdata);
    endtask

    initial begin
        txn_res_t      r;
        int            acks_own[$];
        int            acks_cyc[$];
        int            both;
        int            nack;
        bit            found;
        logic [DW-1:0] rd_seen;
        bit            pend[2];
        bit            rwe[2];
        logic [AW-1:0] raddr[2];
        logic [DW-1:0] rwdata[2];

        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset busy",      32'(bus.busy),            32'(0));
        check("reset cpu_ack",   32'(bus.cpu_ack),         32'(0));
        check("reset cpu_rdata", 32'(bus.cpu_rdata),       32'(0));
        check("reset mem_addr",  32'(bus.mem_access_addr), 32'(0));
        tick();
        rst = 1'b0;

        // cpu write, then read back
        run_txn(1'b0, 1'b1, 16'd3, 16'hA5A5, r);
        check("tp1 ack latency",    32'(r.lat),               32'(2));
        check("tp1 write strobes",  32'(r.n_wr),              32'(1));
        check("tp1 read strobes",   32'(r.n_rd),              32'(0));
        check("tp1 busy cycles",    32'(r.n_busy),            32'(2));
        check("tp1 dbg_ack cycles", 32'(r.n_other),           32'(0));
        check("tp1 held addr",      32'(bus.mem_access_addr), 32'(3));
        run_txn(1'b0, 1'b0, 16'd3, 16'h0000, r);
        check("tp2 rdata",          32'(r.rdata),             32'(16'hA5A5));
        check("tp2 read strobes",   32'(r.n_rd),              32'(1));
        check("tp2 write strobes",  32'(r.n_wr),              32'(0));
        repeat (3) tick();
        @(negedge clk);
        check("tp2 rdata held",     32'(bus.cpu_rdata),       32'(16'hA5A5));
        check("tp2 model rdata",    32'(m_cpu_rd),            32'(16'hA5A5));

        // both ports held from reset: grants alternate starting with cpu
        tick();
        rst = 1'b1;
        set_port(1'b0, 1'b1, 1'b1, 16'd1, 16'h1234);
        set_port(1'b1, 1'b1, 1'b0, 16'd5, 16'h0000);
        tick(); tick();
        rst = 1'b0;
        both = 0;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (bus.cpu_ack && bus.dbg_ack) both++;
            if (bus.cpu_ack) begin acks_own.push_back(0); acks_cyc.push_back(i); end
            if (bus.dbg_ack) begin acks_own.push_back(1); acks_cyc.push_back(i); end
        end
        check("tp3 both acks high", 32'(both),            32'(0));
        check("tp3 ack count",      32'(acks_own.size()), 32'(4));
        if (acks_own.size() == 4) begin
            for (int i = 0; i < 4; i++) check("tp3 grant order", 32'(acks_own[i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("tp3 ack spacing", 32'(acks_cyc[i] - acks_cyc[i-1]), 32'(3));
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (4) tick();

        // full address passed through; the memory aliases 9 onto 1
        run_txn(1'b1, 1'b1, 16'd9, 16'h0007, r);
        check("tp4 addr passthrough", 32'(bus.mem_access_addr), 32'(9));
        run_txn(1'b0, 1'b0, 16'd1, 16'h0000, r);
        check("tp4 aliased rdata",    32'(r.rdata),             32'(16'h0007));
        check("tp4 model mem[1]",     32'(m_mem[1]),            32'(16'h0007));

        // reset in the SERVE cycle of a write suppresses it and its ack
        run_txn(1'b0, 1'b1, 16'd2, 16'h2222, r);
        set_port(1'b0, 1'b1, 1'b1, 16'd2, 16'hFFFF);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.mem_write_en;
        end
        check("tp5 write reached", 32'(found), 32'(1));
        rst = 1'b1;
        set_port(1'b0, 1'b0, 1'b0, 16'd2, 16'h0000);
        @(negedge clk);
        check("tp5 write blocked", 32'(bus.mem_write_en), 32'(0));
        tick();
        rst = 1'b0;
        nack = 0;
        repeat (4) begin tick(); nack += int'(bus.cpu_ack); end
        check("tp5 no ack", 32'(nack), 32'(0));
        run_txn(1'b0, 1'b0, 16'd2, 16'h0000, r);
        check("tp5 prior value", 32'(r.rdata), 32'(16'h2222));

        // req dropped during SERVE: access still completes with one ack
        set_port(1'b0, 1'b1, 1'b0, 16'd3, 16'h0000);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = bus.mem_read;
        end
        check("tp6 read reached", 32'(found), 32'(1));
        set_port(1'b0, 1'b0, 1'b0, 16'd3, 16'h0000);
        nack = 0;
        rd_seen = '0;
        repeat (5) begin
            tick();
            if (bus.cpu_ack) begin nack++; rd_seen = bus.cpu_rdata; end
        end
        check("tp6 ack count", 32'(nack),     32'(1));
        check("tp6 rdata",     32'(rd_seen),  32'(16'hA5A5));
        check("tp6 idle",      32'(bus.busy), 32'(0));

        // randomized traffic from both ports, with occasional resets
        pend = '{1'b0, 1'b0};
        rwe = '{1'b0, 1'b0};
        raddr = '{'0, '0};
        rwdata = '{'0, '0};
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b1;
                pend = '{1'b0, 1'b0};
                set_port(1'b0, 1'b0, 1'b0, '0, '0);
                set_port(1'b1, 1'b0, 1'b0, '0, '0);
                tick();
                rst = 1'b0;
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (pend[p] && ack_of(p[0])) pend[p] = 1'b0;
                    if (!pend[p] && $urandom_range(0, 2) == 0) begin
                        pend[p]   = 1'b1;
                        rwe[p]    = 1'($urandom_range(0, 1));
                        raddr[p]  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
                        rwdata[p] = DW'($urandom);
                    end
                    set_port(p[0], pend[p], rwe[p], raddr[p], rwdata[p]);
                end
                tick();
            end
        end
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
